// File: rtl/icache_read_responder_pkg.sv
// Shared types for the direct-mapped instruction cache responder.
// Address split: | tag | index | word offset | byte [1:0] |
package ICacheTypes;

  localparam int FETCH_WIDTH = 2;
  localparam int LINE_WORDS  = 4;
  localparam int NUM_SETS    = 64;
  localparam int ADDR_WIDTH  = 32;

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [OFF_W-1:0]      off_t;
  typedef logic [OFF_W:0]        lane_t;
  typedef logic [31:0]           word_t;

  typedef logic [LINE_WORDS-1:0][31:0]  line_t;
  typedef logic [FETCH_WIDTH-1:0][31:0] fetch_t;
  typedef logic [FETCH_WIDTH-1:0]       hit_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } fill_state_e;

  function automatic off_t get_off(addr_t a);
    return a[2 +: OFF_W];
  endfunction

  function automatic idx_t get_idx(addr_t a);
    return a[OFF_W+2 +: IDX_W];
  endfunction

  function automatic tag_t get_tag(addr_t a);
    return a[ADDR_WIDTH-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/icache_read_responder_if.sv
// Fetch-side and memory-side bundle of the I-cache responder.
// ICACHE_PERF_COUNTER_EN adds hitCount/missCount.
interface icache_read_responder_if;
  import ICacheTypes::*;

  logic   icRE;
  addr_t  icReadAddrIn;
  logic   icFlush;
  hit_t   icReadHit;
  fetch_t icReadDataOut;
  logic   memReq;
  addr_t  memAddr;
  logic   memReqAck;
  logic   memRespValid;
  word_t  memRespData;
`ifdef ICACHE_PERF_COUNTER_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  modport slave (
    input  icRE, icReadAddrIn, icFlush,
    output icReadHit, icReadDataOut,
    output memReq, memAddr,
    input  memReqAck, memRespValid, memRespData
`ifdef ICACHE_PERF_COUNTER_EN
    , output hitCount, missCount
`endif
  );

  modport master (
    output icRE, icReadAddrIn, icFlush,
    input  icReadHit, icReadDataOut,
    input  memReq, memAddr,
    output memReqAck, memRespValid, memRespData
`ifdef ICACHE_PERF_COUNTER_EN
    , input hitCount, missCount
`endif
  );

endinterface

// File: rtl/icache_read_responder_fill_fsm.sv
// Line-fill sequencer: request/ack, beat collection, array write pulse.
// A flush seen during the fill suppresses validation of the line.
module icache_fill_fsm
  import ICacheTypes::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  addr_t       line_addr,
  input  logic        flush,
  input  logic        mem_req_ack,
  input  logic        mem_resp_valid,
  input  word_t       mem_resp_data,
  output fill_state_e state,
  output logic        mem_req,
  output addr_t       mem_addr,
  output logic        wr_en,
  output logic        wr_valid,
  output line_t       wr_line
);

  localparam off_t LAST = off_t'(LINE_WORDS - 1);

  off_t  cnt;
  line_t buffer;
  logic  flushed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      flushed <= 1'b0;
      buffer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= line_addr;
            flushed  <= 1'b0;
            cnt      <= '0;
          end
        end
        REQ: begin
          flushed <= flushed | flush;
          if (mem_req_ack) begin
            state   <= FILL;
            mem_req <= 1'b0;
          end
        end
        FILL: begin
          flushed <= flushed | flush;
          if (mem_resp_valid) begin
            buffer[cnt] <= mem_resp_data;
            cnt         <= cnt + off_t'(1);
            if (cnt == LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Last beat bypasses the buffer so the arrays update on that same edge
  always_comb begin
    wr_line = buffer;
    wr_line[LINE_WORDS-1] = mem_resp_data;
  end

  assign wr_en = (state == FILL) & mem_resp_valid & (cnt == LAST);
  assign wr_valid = ~(flushed | flush);

endmodule

// File: rtl/icache_read_responder.sv
// Direct-mapped I-cache read responder: arrays, lane mux, hit logic.
// ICACHE_PERF_COUNTER_EN adds saturating hit/miss counters.
module icache_read_responder
  import ICacheTypes::*;
(
  input logic clk,
  input logic rst,
  icache_read_responder_if.slave bus
);

  fill_state_e state;
  logic  idle;
  logic  start;
  addr_t line_addr;
  logic  mem_req;
  addr_t mem_addr;
  logic  wr_en;
  logic  wr_valid;
  line_t wr_line;

  logic [NUM_SETS-1:0] valid;
  line_t data_ram [NUM_SETS];
  tag_t  tag_ram [NUM_SETS];

  logic  re_q;
  logic  vld_q;
  off_t  off_q;
  idx_t  idx_q;
  tag_t  tag_in;
  line_t line_q;
  tag_t  tag_q;

  hit_t   hit;
  fetch_t data;
  logic   tag_ok;
  lane_t  lane;

  assign idle = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= '0;
      re_q   <= 1'b0;
      vld_q  <= 1'b0;
      off_q  <= '0;
      idx_q  <= '0;
      tag_in <= '0;
    end else begin
      if (bus.icFlush) valid <= '0;
      else if (wr_en && wr_valid) valid[get_idx(mem_addr)] <= 1'b1;
      re_q   <= bus.icRE & idle;
      vld_q  <= valid[get_idx(bus.icReadAddrIn)] & ~bus.icFlush;
      off_q  <= get_off(bus.icReadAddrIn);
      idx_q  <= get_idx(bus.icReadAddrIn);
      tag_in <= get_tag(bus.icReadAddrIn);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_ram[get_idx(mem_addr)] <= wr_line;
      tag_ram[get_idx(mem_addr)]  <= get_tag(mem_addr);
    end
    line_q <= data_ram[get_idx(bus.icReadAddrIn)];
    tag_q  <= tag_ram[get_idx(bus.icReadAddrIn)];
  end

  // Lanes past the end of the line never hit; no cross-line fetch
  always_comb begin
    hit    = '0;
    data   = '0;
    lane   = '0;
    tag_ok = re_q & idle & vld_q & (tag_q == tag_in);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane = {1'b0, off_q} + lane_t'(i);
      if (tag_ok && lane < lane_t'(LINE_WORDS)) begin
        hit[i]  = 1'b1;
        data[i] = line_q[lane[OFF_W-1:0]];
      end
    end
  end

  assign start     = re_q & idle & ~hit[0];
  assign line_addr = {tag_in, idx_q, {(OFF_W+2){1'b0}}};

  icache_fill_fsm u_fill (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .line_addr      (line_addr),
    .flush          (bus.icFlush),
    .mem_req_ack    (bus.memReqAck),
    .mem_resp_valid (bus.memRespValid),
    .mem_resp_data  (bus.memRespData),
    .state          (state),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .wr_en          (wr_en),
    .wr_valid       (wr_valid),
    .wr_line        (wr_line)
  );

  assign bus.icReadHit     = hit;
  assign bus.icReadDataOut = data;
  assign bus.memReq        = mem_req;
  assign bus.memAddr       = mem_addr;

`ifdef ICACHE_PERF_COUNTER_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit[0] && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (start && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hitCount  = hit_cnt;
  assign bus.missCount = miss_cnt;
`endif

endmodule

// File: tb/tb_icache_read_responder.sv
// Scoreboard bench for icache_read_responder.
// Reads push expectations; a negedge monitor pops and compares.
module tb_icache_read_responder;
  import ICacheTypes::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_read_responder_if bus();

  icache_read_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  hit;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic re_s = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) re_s <= bus.icRE;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (re_s) begin
      if (q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("hit", 64'(bus.icReadHit), 64'(e.hit));
        check("lane0", 64'(bus.icReadDataOut[0]), 64'(e.d0));
        check("lane1", 64'(bus.icReadDataOut[1]), 64'(e.d1));
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [1:0] h,
                    input logic [31:0] d0, input logic [31:0] d1);
    bus.icRE = 1'b1;
    bus.icReadAddrIn = a;
    q.push_back('{h, d0, d1});
    @(negedge clk);
    bus.icRE = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (bus.memReq) got = 1'b1;
      else @(negedge clk);
    end
    check("memReq_seen", 64'(got), 64'd1);
    check("memAddr", 64'(bus.memAddr), 64'(a));
  endtask

  // Missed reads of the filling line are issued every cycle
  task automatic fill(input logic [31:0] base, input logic [31:0] a,
                      input logic fl);
    bus.icReadAddrIn = a;
    bus.icRE = 1'b1;
    bus.memReqAck = 1'b1;
    q.push_back('{2'b00, 32'd0, 32'd0});
    @(negedge clk);
    bus.memReqAck = 1'b0;
    check("memReq_drop", 64'(bus.memReq), 64'd0);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        bus.memRespValid = 1'b0;
        q.push_back('{2'b00, 32'd0, 32'd0});
        @(negedge clk);
      end
      bus.memRespValid = 1'b1;
      bus.memRespData = base + 32'(b);
      bus.icFlush = fl && (b == 3);
      q.push_back('{2'b00, 32'd0, 32'd0});
      @(negedge clk);
    end
    bus.memRespValid = 1'b0;
    bus.icFlush = 1'b0;
    bus.icRE = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.icRE = 1'b0;
    bus.icReadAddrIn = '0;
    bus.icFlush = 1'b0;
    bus.memReqAck = 1'b0;
    bus.memRespValid = 1'b0;
    bus.memRespData = '0;
    repeat (2) @(negedge clk);
    check("rst_hit", 64'(bus.icReadHit), 64'd0);
    check("rst_data", 64'(bus.icReadDataOut), 64'd0);
    check("rst_memReq", 64'(bus.memReq), 64'd0);
    check("rst_memAddr", 64'(bus.memAddr), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    rd(32'h1000, 2'b00, 0, 0);
    wait_req(32'h1000);
    rd(32'h1000, 2'b00, 0, 0);
    rd(32'h1000, 2'b00, 0, 0);
    check("memReq_hold", 64'(bus.memReq), 64'd1);
    fill(32'hA0, 32'h1000, 1'b0);
    check("one_fill", 64'(bus.memReq), 64'd0);

    rd(32'h1004, 2'b11, 32'hA1, 32'hA2);
    rd(32'h100C, 2'b01, 32'hA3, 32'h0);
    rd(32'h1000, 2'b11, 32'hA0, 32'hA1);
    rd(32'h1008, 2'b11, 32'hA2, 32'hA3);
    @(negedge clk);
    check("no_edge_fill", 64'(bus.memReq), 64'd0);

    rd(32'h2000, 2'b00, 0, 0);
    wait_req(32'h2000);
    fill(32'hB0, 32'h2000, 1'b0);
    rd(32'h2000, 2'b11, 32'hB0, 32'hB1);
    rd(32'h1000, 2'b00, 0, 0);
    wait_req(32'h1000);
    fill(32'hA0, 32'h1000, 1'b0);
    rd(32'h1004, 2'b11, 32'hA1, 32'hA2);

    rd(32'h3000, 2'b00, 0, 0);
    wait_req(32'h3000);
    fill(32'hC0, 32'h3000, 1'b1);
    rd(32'h3000, 2'b00, 0, 0);
    wait_req(32'h3000);
    fill(32'hD0, 32'h3000, 1'b0);
    rd(32'h3004, 2'b11, 32'hD1, 32'hD2);

    rd(32'h4010, 2'b00, 0, 0);
    wait_req(32'h4010);
    bus.memReqAck = 1'b1;
    @(negedge clk);
    bus.memReqAck = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.memRespValid = 1'b1;
      bus.memRespData = 32'hF0 + 32'(b);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("mid_rst_memReq", 64'(bus.memReq), 64'd0);
    check("mid_rst_memAddr", 64'(bus.memAddr), 64'd0);
    check("mid_rst_hit", 64'(bus.icReadHit), 64'd0);
    check("mid_rst_data", 64'(bus.icReadDataOut), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.memRespValid = 1'b0;
    @(negedge clk);
    check("stray_memReq", 64'(bus.memReq), 64'd0);
    rd(32'h4010, 2'b00, 0, 0);
    wait_req(32'h4010);
    fill(32'hE0, 32'h4010, 1'b0);
    rd(32'h4018, 2'b11, 32'hE2, 32'hE3);

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
